// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I field-to-word encoder that streams a program into IMEM
module inst_encoder #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [4:0]        req_op,
    input  logic [2:0]        req_funct3,
    input  logic              req_alt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [4:0]  OP_LUI    = 5'b01101;
    localparam logic [4:0]  OP_AUIPC  = 5'b00101;
    localparam logic [4:0]  OP_JAL    = 5'b11011;
    localparam logic [4:0]  OP_JALR   = 5'b11001;
    localparam logic [4:0]  OP_BRANCH = 5'b11000;
    localparam logic [4:0]  OP_LOAD   = 5'b00000;
    localparam logic [4:0]  OP_STORE  = 5'b01000;
    localparam logic [4:0]  OP_OPIMM  = 5'b00100;
    localparam logic [4:0]  OP_OP     = 5'b01100;
    localparam logic [4:0]  OP_SYSTEM = 5'b11100;

    localparam logic [31:0] WORD_ECALL = 32'h0000_0073;
    localparam logic [31:0] WORD_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_TERM,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              ecall_sent;

    logic              req_fire;
    logic              wr_taken;
    logic              start_ok;

    logic [6:0]        opcode;
    logic              imm12_ok;
    logic              imm13_ok;
    logic              imm21_ok;
    logic              shamt_ok;
    logic              is_shift;
    logic [31:0]       enc_raw;
    logic              enc_illegal;
    logic [31:0]       enc_word;

    assign req_fire = req_valid && req_ready;
    assign wr_taken = mem_wr_en && mem_ready;
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

    // Immediate range checks: the upper bits must be a pure sign extension
    assign imm12_ok = (&req_imm[31:11]) || !(|req_imm[31:11]);
    assign imm13_ok = (&req_imm[31:12]) || !(|req_imm[31:12]);
    assign imm21_ok = (&req_imm[31:20]) || !(|req_imm[31:20]);
    assign shamt_ok = !(|req_imm[31:5]);
    assign is_shift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
    assign opcode   = {req_op, 2'b11};

    // Format selection and legality of the presented request; illegal fields become a NOP
    always_comb begin
        enc_raw     = 32'h0;
        enc_illegal = 1'b0;
        case (req_op)
            OP_LUI, OP_AUIPC: begin
                enc_raw = {req_imm[31:12], req_rd, opcode};
            end
            OP_JAL: begin
                enc_raw     = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, opcode};
                enc_illegal = !imm21_ok || req_imm[0];
            end
            OP_JALR, OP_LOAD: begin
                enc_raw     = {req_imm[11:0], req_rs1, req_funct3, req_rd, opcode};
                enc_illegal = !imm12_ok;
            end
            OP_OPIMM: begin
                if (is_shift) begin
                    enc_raw     = {1'b0, req_alt, 5'b0, req_imm[4:0], req_rs1, req_funct3, req_rd, opcode};
                    enc_illegal = !shamt_ok || (req_alt && (req_funct3 != 3'b101));
                end else begin
                    enc_raw     = {req_imm[11:0], req_rs1, req_funct3, req_rd, opcode};
                    enc_illegal = !imm12_ok || req_alt;
                end
            end
            OP_BRANCH: begin
                enc_raw     = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                               req_imm[4:1], req_imm[11], opcode};
                enc_illegal = !imm13_ok || req_imm[0] ||
                              (req_funct3 == 3'b010) || (req_funct3 == 3'b011);
            end
            OP_STORE: begin
                enc_raw     = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], opcode};
                enc_illegal = !imm12_ok;
            end
            OP_OP: begin
                enc_raw     = {1'b0, req_alt, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, opcode};
                enc_illegal = req_alt && (req_funct3 != 3'b000) && (req_funct3 != 3'b101);
            end
            OP_SYSTEM: begin
                enc_raw = WORD_ECALL;
            end
            default: begin
                enc_illegal = 1'b1;
            end
        endcase
        enc_word = enc_illegal ? WORD_NOP : enc_raw;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the handshake and status outputs decoded from state
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                busy      = 1'b1;
                req_ready = !mem_wr_en || mem_ready;
                if (req_fire && req_last) begin
                    state_nxt = S_TERM;
                end
            end
            S_TERM: begin
                busy = 1'b1;
                if (ecall_sent && wr_taken) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_ACCEPT;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Write port, address counter and status flags; a write stays on the bus until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            addr_cnt   <= '0;
            ecall_sent <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == S_TERM) && ecall_sent && wr_taken;
            if (start_ok) begin
                err        <= 1'b0;
                addr_cnt   <= start_addr;
                ecall_sent <= 1'b0;
            end
            case (state)
                S_ACCEPT: begin
                    if (req_fire) begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= addr_cnt;
                        mem_wdata <= enc_word;
                        addr_cnt  <= addr_cnt + ADDR_W'(4);
                        if (enc_illegal) begin
                            err <= 1'b1;
                        end
                    end else if (wr_taken) begin
                        mem_wr_en <= 1'b0;
                    end
                end
                S_TERM: begin
                    if (!ecall_sent && (!mem_wr_en || mem_ready)) begin
                        mem_wr_en  <= 1'b1;
                        mem_addr   <= addr_cnt;
                        mem_wdata  <= WORD_ECALL;
                        addr_cnt   <= addr_cnt + ADDR_W'(4);
                        ecall_sent <= 1'b1;
                    end else if (ecall_sent && wr_taken) begin
                        mem_wr_en <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - randomized scoreboard bench for inst_encoder
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] start_addr;
    logic        req_valid;
    logic        req_ready;
    logic        req_last;
    logic [4:0]  req_op;
    logic [2:0]  req_funct3;
    logic        req_alt;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        err;

    inst_encoder #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .req_op(req_op), .req_funct3(req_funct3), .req_alt(req_alt),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          is_end;
    } exp_t;

    int     n_tests = 0;
    int     n_fail = 0;
    exp_t   exp_q[$];
    req_t   prog[$];
    int     ends_seen = 0;
    int     ends_handled = 0;
    bit     exp_active = 0;
    bit     exp_accepting = 0;
    bit     exp_err = 0;
    bit     exp_done = 0;
    logic [31:0] exp_addr = 0;
    bit     prev_hold = 0;
    logic [31:0] prev_addr = 0;
    logic [31:0] prev_data = 0;

    logic [4:0] op_tab [12] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
                                5'b01000, 5'b00100, 5'b01100, 5'b11100, 5'b00011, 5'b11111};
    int imm_tab [16] = '{-4097, -4096, -4095, -2049, -2048, 2047, 2048, 4094,
                         4095, 31, 32, -1, 1048574, 1048576, -1048576, -1048578};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic [4:0] op, input logic [2:0] f3, input logic alt,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm);
        req_t r;
        r.op = op; r.f3 = f3; r.alt = alt; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    // Reference encoder: signed range tests on integers, fields placed by shift-and-mask
    function automatic logic [31:0] model_encode(input req_t r, output bit ill);
        int          si;
        logic [31:0] u, opc, w, f3s, rds, rs1s, rs2s, alts, iimm;
        si   = int'(r.imm);
        u    = r.imm;
        opc  = 32'({r.op, 2'b11});
        rds  = 32'(r.rd) << 7;
        rs1s = 32'(r.rs1) << 15;
        rs2s = 32'(r.rs2) << 20;
        f3s  = 32'(r.f3) << 12;
        alts = 32'(r.alt) << 30;
        iimm = (u & 32'hFFF) << 20;
        ill  = 0;
        w    = 0;
        case (r.op)
            5'b01101, 5'b00101: w = (u & 32'hFFFF_F000) | rds | opc;
            5'b11011: begin
                ill = (si < -(1 << 20)) || (si > (1 << 20) - 2) || (si % 2 != 0);
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                    (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | rds | opc;
            end
            5'b11001, 5'b00000: begin
                ill = (si < -2048) || (si > 2047);
                w = iimm | rs1s | f3s | rds | opc;
            end
            5'b00100: begin
                if (r.f3 == 3'd1 || r.f3 == 3'd5) begin
                    ill = (u > 31) || (r.alt && r.f3 != 3'd5);
                    w = alts | ((u & 31) << 20) | rs1s | f3s | rds | opc;
                end else begin
                    ill = (si < -2048) || (si > 2047) || r.alt;
                    w = iimm | rs1s | f3s | rds | opc;
                end
            end
            5'b11000: begin
                ill = (si < -4096) || (si > 4094) || (si % 2 != 0) || r.f3 == 3'd2 || r.f3 == 3'd3;
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | rs2s | rs1s | f3s |
                    (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | opc;
            end
            5'b01000: begin
                ill = (si < -2048) || (si > 2047);
                w = (((u >> 5) & 127) << 25) | rs2s | rs1s | f3s | ((u & 31) << 7) | opc;
            end
            5'b01100: begin
                ill = r.alt && r.f3 != 3'd0 && r.f3 != 3'd5;
                w = alts | rs2s | rs1s | f3s | rds | opc;
            end
            5'b11100: w = 32'h0000_0073;
            default:  ill = 1;
        endcase
        return ill ? 32'h0000_0013 : w;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.op  = op_tab[$urandom_range(0, 11)];
        r.f3  = 3'($urandom);
        r.alt = ($urandom_range(0, 3) == 0);
        r.rd  = 5'($urandom);
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        case ($urandom_range(0, 3))
            0:       r.imm = 32'($urandom_range(0, 63)) - 32'd32;
            1:       r.imm = imm_tab[$urandom_range(0, 15)];
            2:       r.imm = $urandom;
            default: r.imm = ($urandom & 32'h001F_FFFE) - 32'h0010_0000;
        endcase
        return r;
    endfunction

    // Compare process: every cycle, outputs against the model; taken writes against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                check("reset_ctrl", 64'({mem_wr_en, req_ready, busy, done, err}), 64'h0);
                check("reset_bus", {mem_addr, mem_wdata}, 64'h0);
                prev_hold = 0;
            end else begin
                check("req_ready", 64'(req_ready), 64'(exp_accepting && (!mem_wr_en || mem_ready)));
                check("busy", 64'(busy), 64'(exp_active));
                check("done", 64'(done), 64'(exp_done));
                check("err", 64'(err), 64'(exp_err));
                if (prev_hold) begin
                    check("hold_stable", {31'h0, mem_wr_en, mem_addr, mem_wdata} ^ {32'h1, prev_addr, prev_data}, 64'h0);
                end
                if (mem_wr_en && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("write_addr", 64'(mem_addr), 64'(e.addr));
                        check("write_data", 64'(mem_wdata), 64'(e.data));
                        if (e.is_end) ends_seen++;
                    end
                end
                prev_hold = mem_wr_en && !mem_ready;
                prev_addr = mem_addr;
                prev_data = mem_wdata;
            end
        end
    end

    task automatic model_tick(input bit set_err, input bit last_acc);
        exp_done = (ends_seen != ends_handled);
        ends_handled = ends_seen;
        if (exp_done) exp_active = 0;
        if (set_err) exp_err = 1;
        if (last_acc) exp_accepting = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            req_valid = 0; start = 0; mem_ready = 1;
            #1;
            @(posedge clk);
            model_tick(0, 0);
            @(negedge clk);
        end
    endtask

    // Run the queued program from saddr; abort_term pulls reset while the last write is stalled
    task automatic run_prog(input logic [31:0] saddr, input int ready_pct, input bit abort_term);
        int  idx = 0;
        int  cyc = 0;
        int  term_cyc = 0;
        int  stall = 0;
        bit  fire, ill, set_err, last_acc;
        logic [31:0] w;
        start = 1; start_addr = saddr; req_valid = 0; mem_ready = 1;
        #1;
        @(posedge clk);
        model_tick(0, 0);
        exp_active = 1; exp_accepting = 1; exp_err = 0; exp_addr = saddr;
        @(negedge clk);
        start = 0;
        while (exp_active && cyc < 4000) begin
            if (stall > 0) begin
                mem_ready = 0; stall--;
            end else if ($urandom_range(0, 99) < 8) begin
                mem_ready = 0; stall = 2;
            end else begin
                mem_ready = ($urandom_range(0, 99) < ready_pct);
            end
            start = ($urandom_range(0, 29) == 0);
            start_addr = $urandom;
            if (exp_accepting && idx < prog.size() && $urandom_range(0, 99) < 75) begin
                req_valid  = 1;
                req_op     = prog[idx].op;
                req_funct3 = prog[idx].f3;
                req_alt    = prog[idx].alt;
                req_rd     = prog[idx].rd;
                req_rs1    = prog[idx].rs1;
                req_rs2    = prog[idx].rs2;
                req_imm    = prog[idx].imm;
                req_last   = (idx == prog.size() - 1);
            end else begin
                req_valid = 0;
            end
            if (abort_term && !exp_accepting) begin
                mem_ready = 0;
                start = 0;
                term_cyc++;
                if (term_cyc == 3) begin
                    rst_n = 0;
                    req_valid = 0;
                    exp_q.delete();
                    exp_active = 0; exp_accepting = 0; exp_err = 0; exp_done = 0;
                    ends_handled = ends_seen;
                    repeat (3) @(negedge clk);
                    rst_n = 1;
                    return;
                end
            end
            #1;
            fire = req_valid && req_ready;
            set_err = 0;
            last_acc = 0;
            if (fire) begin
                w = model_encode(prog[idx], ill);
                exp_q.push_back('{exp_addr, w, 1'b0});
                exp_addr += 4;
                set_err = ill;
                if (req_last) begin
                    exp_q.push_back('{exp_addr, 32'h0000_0073, 1'b1});
                    exp_addr += 4;
                    last_acc = 1;
                end
                idx++;
            end
            @(posedge clk);
            model_tick(set_err, last_acc);
            @(negedge clk);
            cyc++;
        end
        start = 0;
        req_valid = 0;
        check("prog_finished", 64'(exp_active), 64'h0);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic gen_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(rand_req());
    endtask

    initial begin
        bit          ill;
        logic [31:0] w;
        rst_n = 0; start = 0; start_addr = 0; req_valid = 0; req_last = 0;
        req_op = 0; req_funct3 = 0; req_alt = 0; req_rd = 0; req_rs1 = 0; req_rs2 = 0;
        req_imm = 0; mem_ready = 0;

        w = model_encode(mk(5'b00100, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5), ill);
        check("pin_addi", 64'(w), 64'h0050_0093);
        w = model_encode(mk(5'b11000, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd8), ill);
        check("pin_beq", 64'(w), 64'h0020_8463);
        w = model_encode(mk(5'b01100, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'd0), ill);
        check("pin_sub", 64'(w), 64'h4020_81B3);
        w = model_encode(mk(5'b01101, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h1234_5000), ill);
        check("pin_lui", 64'(w), 64'h1234_52B7);
        w = model_encode(mk(5'b11011, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd2048), ill);
        check("pin_jal", 64'(w), 64'h0010_00EF);
        w = model_encode(mk(5'b00100, 3'd5, 1, 5'd1, 5'd2, 5'd0, 32'd3), ill);
        check("pin_srai", 64'(w), 64'h4031_5093);
        w = model_encode(mk(5'b11000, 3'd0, 0, 5'd0, 5'd0, 5'd0, -32'sd4), ill);
        check("pin_beq_back", 64'(w), 64'hFE00_0EE3);
        w = model_encode(mk(5'b00100, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd2048), ill);
        check("pin_addi_2048", {31'h0, ill, w}, {31'h0, 1'b1, 32'h0000_0013});

        repeat (3) @(negedge clk);
        rst_n = 1;
        idle_cycles(2);

        prog.delete();
        prog.push_back(mk(5'b00100, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5));
        prog.push_back(mk(5'b11000, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd8));
        prog.push_back(mk(5'b01100, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'd0));
        prog.push_back(mk(5'b01101, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h1234_5000));
        prog.push_back(mk(5'b11011, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd2048));
        run_prog(32'h0000_0100, 100, 0);
        check("directed_err_clear", 64'(err), 64'h0);
        idle_cycles(2);

        prog.delete();
        prog.push_back(mk(5'b00100, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd2048));
        run_prog(32'h0000_0200, 100, 0);
        check("illegal_err_sticky", 64'(err), 64'h1);
        idle_cycles(2);
        check("illegal_err_held", 64'(err), 64'h1);

        for (int p = 0; p < 12; p++) begin
            gen_prog($urandom_range(1, 20));
            run_prog((p == 5) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC), $urandom_range(40, 100), 0);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        gen_prog(4);
        run_prog(32'h0000_0300, 100, 1);
        idle_cycles(3);
        check("after_abort_idle", 64'({busy, mem_wr_en, err}), 64'h0);

        gen_prog(6);
        run_prog(32'h0000_0400, 80, 0);
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
